// File: rtl/useq_ctl.sv
// useq_ctl: microcode sequencer driving an external synchronous microcode ROM.
// Computes the next ROM address from the current word's op field, the opcode
// bus, condition flags, a two-deep micro-subroutine stack, a finisher register
// and prioritised interrupt sources (edge- or level-triggered per source).
//
// Advance handshake: rdy is the single advance qualifier. With rdy=1 the
// address on rom_addr is accepted by the ROM and by cur_addr_q in the same
// clock, and all sequencer state updates. With rdy=0 the ROM holds its output,
// all sequencer state holds, irq_ack stays 0, and only edge capture runs.
module useq_ctl #(
    parameter int              AW         = 9,
    parameter int              UW         = 32,
    parameter int              NCOND      = 8,
    parameter int              FW         = 5,
    parameter logic [AW-2:0]   FIN_BASE   = 8'h40,
    parameter int              NIRQ       = 4,
    parameter logic [NIRQ-1:0] EDGE_MASK  = 4'b1000,
    parameter logic [AW-2:0]   VEC_BASE   = 8'hE0,
    parameter int              VEC_SHIFT  = 2,
    parameter logic [AW-1:0]   RESET_ADDR = 9'h1F0,
    parameter int              WE_BIT     = 28
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rdy,
    input  logic [AW-2:0]    DB,
    input  logic [UW-1:0]    uc,
    input  logic [NCOND-1:0] cond,
    input  logic [NIRQ-1:0]  irq,
    input  logic [NIRQ-1:0]  irq_mask,
    output logic [AW-1:0]    rom_addr,
    output logic             sync,
    output logic             WE,
    output logic [NIRQ-1:0]  irq_ack,
    output logic             stk_err
);

    localparam int NA  = AW - 1;
    localparam int CSW = (NCOND > 1) ? $clog2(NCOND) : 1;
    localparam int IW  = (NIRQ > 1) ? $clog2(NIRQ) : 1;
    localparam int SD  = 2;
    localparam logic [NA-1:0] FIN_LOW = NA'((1 << FW) - 1);

    typedef enum logic [2:0] {
        OP_FETCH     = 3'd0,
        OP_NEXT      = 3'd1,
        OP_FINISH    = 3'd2,
        OP_NEXT_SAVE = 3'd3,
        OP_BRANCH    = 3'd4,
        OP_CALL      = 3'd5,
        OP_RET       = 3'd6,
        OP_FETCH_NI  = 3'd7
    } op_e;

    // Word fields
    op_e            op;
    logic [NA-1:0]  tgt;
    logic [CSW-1:0] csel;
    logic           cpol;
    logic [FW-1:0]  fin;
    logic           unused_uc;

    assign op        = op_e'(uc[2:0]);
    assign tgt       = uc[3 +: NA];
    assign csel      = uc[3+NA +: CSW];
    assign cpol      = uc[3+NA+CSW];
    assign fin       = uc[4+NA+CSW +: FW];
    assign unused_uc = ^uc;

    // Sequencer state
    logic [AW-1:0]   cur_addr_q;
    logic [FW-1:0]   finish_q, finish_d;
    logic [NA-1:0]   stk_q [SD];
    logic [NA-1:0]   stk_d [SD];
    logic [1:0]      sp_q, sp_d;       // entries in use, 0..SD
    logic [NIRQ-1:0] pend_q, pend_d;
    logic [NIRQ-1:0] irq_d_q;
    logic            we_q;
    logic            stk_err_q, stk_err_d;

    // Interrupt request selection
    logic [NIRQ-1:0] req;
    logic [IW-1:0]   win;
    logic [NA-1:0]   vec;
    logic [NIRQ-1:0] ack_raw;
    logic [NA-1:0]   inc;
    logic [NA-1:0]   fin_addr;

    assign req      = ~irq_mask & ((EDGE_MASK & pend_q) | (~EDGE_MASK & irq));
    assign vec      = VEC_BASE + (NA'(win) << VEC_SHIFT);
    assign inc      = cur_addr_q[NA-1:0] + NA'(1);
    assign fin_addr = (FIN_BASE & ~FIN_LOW) | NA'(finish_q);

    // Highest set request index wins
    always_comb begin
        win = '0;
        for (int i = 0; i < NIRQ; i++) begin
            if (req[i]) win = IW'(i);
        end
    end

    // Next-address decode plus finisher/stack next state
    always_comb begin
        rom_addr  = {1'b1, tgt};
        ack_raw   = '0;
        finish_d  = finish_q;
        stk_d     = stk_q;
        sp_d      = sp_q;
        stk_err_d = stk_err_q;
        case (op)
            OP_FETCH: begin
                if (|req) begin
                    rom_addr     = {1'b1, vec};
                    ack_raw[win] = 1'b1;
                end else begin
                    rom_addr = {1'b0, DB};
                end
            end
            OP_FETCH_NI:  rom_addr = {1'b0, DB};
            OP_NEXT:      rom_addr = {1'b1, tgt};
            OP_FINISH:    rom_addr = {1'b1, fin_addr};
            OP_NEXT_SAVE: begin
                rom_addr = {1'b1, tgt};
                finish_d = fin;
            end
            OP_BRANCH: begin
                rom_addr = (cond[csel] ^ cpol) ? {1'b1, tgt} : {1'b1, inc};
            end
            OP_CALL: begin
                rom_addr = {1'b1, tgt};
                if (sp_q == 2'd2) begin
                    // full: drop the oldest return address
                    stk_d[0]  = stk_q[1];
                    stk_d[1]  = inc;
                    stk_err_d = 1'b1;
                end else begin
                    stk_d[sp_q[0]] = inc;
                    sp_d           = sp_q + 2'd1;
                end
            end
            OP_RET: begin
                if (sp_q == 2'd0) begin
                    rom_addr  = {1'b1, {NA{1'b0}}};
                    stk_err_d = 1'b1;
                end else begin
                    rom_addr = {1'b1, stk_q[sp_q[1]]};
                    sp_d     = sp_q - 2'd1;
                end
            end
            default: rom_addr = {1'b1, tgt};
        endcase
        if (reset) rom_addr = RESET_ADDR;
    end

    assign irq_ack = (rdy && !reset) ? ack_raw : '0;
    // A fresh edge in the same cycle as the ack keeps the source pending
    assign pend_d  = EDGE_MASK & ((pend_q & ~irq_ack) | (irq & ~irq_d_q));

    assign sync    = (op == OP_FETCH) || (op == OP_FETCH_NI);
    assign WE      = we_q;
    assign stk_err = stk_err_q;

    // Control registers; edge capture runs every clock, the rest only on rdy
    always_ff @(posedge clk) begin
        if (reset) begin
            cur_addr_q <= RESET_ADDR;
            finish_q   <= '0;
            sp_q       <= '0;
            pend_q     <= '0;
            irq_d_q    <= irq;
            we_q       <= 1'b0;
            stk_err_q  <= 1'b0;
        end else begin
            irq_d_q <= irq;
            pend_q  <= pend_d;
            if (rdy) begin
                cur_addr_q <= rom_addr;
                finish_q   <= finish_d;
                sp_q       <= sp_d;
                we_q       <= uc[WE_BIT];
                stk_err_q  <= stk_err_d;
            end
        end
    end

    // Stack storage; contents are meaningless while sp_q says empty
    always_ff @(posedge clk) begin
        if (rdy && !reset) begin
            stk_q <= stk_d;
        end
    end

endmodule

// File: tb/tb_useq_ctl.sv
// tb_useq_ctl: directed vector table followed by randomized cycles, all
// checked against a behavioural model of the sequencer.
module tb_useq_ctl;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy;
    logic [7:0]  DB;
    logic [31:0] uc;
    logic [7:0]  cond;
    logic [3:0]  irq;
    logic [3:0]  irq_mask;
    logic [8:0]  rom_addr;
    logic        sync;
    logic        WE;
    logic [3:0]  irq_ack;
    logic        stk_err;

    int n_cmp = 0;
    int n_bad = 0;

    useq_ctl dut (
        .clk      (clk),
        .reset    (reset),
        .rdy      (rdy),
        .DB       (DB),
        .uc       (uc),
        .cond     (cond),
        .irq      (irq),
        .irq_mask (irq_mask),
        .rom_addr (rom_addr),
        .sync     (sync),
        .WE       (WE),
        .irq_ack  (irq_ack),
        .stk_err  (stk_err)
    );

    // clock
    always #5 clk = ~clk;

    // behavioural model state
    logic [8:0] m_cur;
    logic [4:0] m_fin;
    logic [7:0] m_stk[$];
    logic [3:0] m_pend;
    logic [3:0] m_irqd;
    logic       m_we;
    logic       m_err;

    typedef struct {
        logic [31:0] w;
        logic [7:0]  db;
        logic [7:0]  cnd;
        logic [3:0]  irqv;
        logic [3:0]  msk;
        logic        rdyv;
        logic        rstv;
        logic [8:0]  ea;
        logic [3:0]  eack;
    } vec_t;

    vec_t tbl[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] mkw(input int op, input int tgt, input int csel,
                                        input int cpol, input int fin, input int we);
        logic [31:0] w;
        w        = '0;
        w[2:0]   = 3'(op);
        w[10:3]  = 8'(tgt);
        w[13:11] = 3'(csel);
        w[14]    = 1'(cpol);
        w[19:15] = 5'(fin);
        w[28]    = 1'(we);
        return w;
    endfunction

    function automatic vec_t mk(input logic [31:0] w, input int db, input int cnd, input int irqv,
                                input int msk, input int rdyv, input int rstv, input int ea, input int eack);
        vec_t v;
        v.w = w; v.db = 8'(db); v.cnd = 8'(cnd); v.irqv = 4'(irqv); v.msk = 4'(msk);
        v.rdyv = 1'(rdyv); v.rstv = 1'(rstv); v.ea = 9'(ea); v.eack = 4'(eack);
        return v;
    endfunction

    logic [8:0] ea;
    logic [3:0] eack;

    // Drive one cycle at negedge, check outputs against the model, advance the model
    task automatic step(input logic [31:0] w, input logic [7:0] db, input logic [7:0] cnd,
                        input logic [3:0] irqv, input logic [3:0] msk, input logic rdyv, input logic rstv);
        int          op;
        int          win;
        logic [3:0]  req;
        logic [3:0]  edg;
        logic [7:0]  tgt;
        logic [7:0]  nxt;
        @(negedge clk);
        uc = w; DB = db; cond = cnd; irq = irqv; irq_mask = msk; rdy = rdyv; reset = rstv;
        #1;
        op  = int'(w[2:0]);
        tgt = w[10:3];
        nxt = m_cur[7:0] + 8'd1;
        req = ~msk & ((m_pend & 4'b1000) | (irqv & 4'b0111));
        win = -1;
        for (int i = 3; i >= 0; i--) if (req[i] && win < 0) win = i;
        eack = 4'b0;
        case (op)
            0: begin
                if (win >= 0) begin
                    ea = {1'b1, 8'(8'hE0 + win * 4)};
                    if (rdyv) eack = 4'(1 << win);
                end else ea = {1'b0, db};
            end
            7: ea = {1'b0, db};
            2: ea = {1'b1, (8'h40 & 8'hE0) | {3'b000, m_fin}};
            4: ea = (cnd[w[13:11]] ^ w[14]) ? {1'b1, tgt} : {1'b1, nxt};
            6: ea = (m_stk.size() == 0) ? 9'h100 : {1'b1, m_stk[$]};
            default: ea = {1'b1, tgt};
        endcase
        if (rstv) begin
            ea = 9'h1F0; eack = 4'b0;
        end
        check("rom_addr", 32'(rom_addr), 32'(ea));
        check("irq_ack", 32'(irq_ack), 32'(eack));
        check("sync", 32'(sync), 32'(op == 0 || op == 7));
        check("WE", 32'(WE), 32'(m_we));
        check("stk_err", 32'(stk_err), 32'(m_err));
        // model update for the coming posedge
        edg = irqv & ~m_irqd & 4'b1000;
        m_irqd = irqv;
        if (rstv) begin
            m_cur = 9'h1F0; m_fin = '0; m_stk.delete(); m_pend = '0; m_we = 1'b0; m_err = 1'b0;
        end else begin
            if (rdyv) begin
                if (op == 3) m_fin = w[19:15];
                if (op == 5) begin
                    m_stk.push_back(nxt);
                    if (m_stk.size() > 2) begin
                        void'(m_stk.pop_front());
                        m_err = 1'b1;
                    end
                end
                if (op == 6) begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else void'(m_stk.pop_back());
                end
                m_pend = m_pend & ~eack;
                m_cur  = ea;
                m_we   = w[28];
            end
            m_pend = m_pend | edg;
        end
    endtask

    initial begin
        logic [3:0] irq_r;
        // reset block
        reset = 1'b1; rdy = 1'b1; DB = '0; uc = '0; cond = '0; irq = '0; irq_mask = '0;
        repeat (2) @(posedge clk);
        m_cur = 9'h1F0; m_fin = '0; m_stk.delete(); m_pend = '0; m_irqd = '0; m_we = 1'b0; m_err = 1'b0;

        // directed vectors: w, db, cond, irq, mask, rdy, reset, exp rom_addr, exp ack
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'hA9, 0, 0, 0, 1, 1, 9'h1F0, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'hA9, 0, 0, 0, 1, 0, 9'h0A9, 0));
        tbl.push_back(mk(mkw(3, 8'h10, 0, 0, 3, 0), 0, 0, 0, 0, 1, 0, 9'h110, 0));
        tbl.push_back(mk(mkw(2, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h143, 0));
        tbl.push_back(mk(mkw(1, 8'hFF, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h1FF, 0));
        tbl.push_back(mk(mkw(4, 8'h20, 2, 0, 0, 0), 0, 8'h00, 0, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(4, 8'h20, 2, 0, 0, 0), 0, 8'h04, 0, 0, 1, 0, 9'h120, 0));
        tbl.push_back(mk(mkw(4, 8'h20, 2, 1, 0, 0), 0, 8'h04, 0, 0, 1, 0, 9'h121, 0));
        tbl.push_back(mk(mkw(4, 8'h20, 2, 1, 0, 0), 0, 8'h00, 0, 0, 1, 0, 9'h120, 0));
        tbl.push_back(mk(mkw(1, 8'h30, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h130, 0));
        tbl.push_back(mk(mkw(5, 8'h50, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h150, 0));
        tbl.push_back(mk(mkw(1, 8'h51, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h151, 0));
        tbl.push_back(mk(mkw(5, 8'h70, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h170, 0));
        tbl.push_back(mk(mkw(6, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h152, 0));
        tbl.push_back(mk(mkw(6, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h131, 0));
        tbl.push_back(mk(mkw(5, 8'h60, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h160, 0));
        tbl.push_back(mk(mkw(5, 8'h61, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h161, 0));
        tbl.push_back(mk(mkw(5, 8'h62, 0, 0, 0, 0), 0, 0, 0, 0, 1, 0, 9'h162, 0));
        tbl.push_back(mk(mkw(6, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h162, 0));
        tbl.push_back(mk(mkw(6, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h161, 0));
        tbl.push_back(mk(mkw(6, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(1, 0, 0, 0, 0, 0),    0, 0, 4'b1001, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h12, 0, 4'b1001, 0, 1, 0, 9'h1EC, 4'b1000));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h12, 0, 4'b1001, 0, 1, 0, 9'h1E0, 4'b0001));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h12, 0, 4'b1001, 4'b0001, 1, 0, 9'h012, 0));
        tbl.push_back(mk(mkw(1, 0, 0, 0, 0, 0),    0, 0, 4'b0001, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(1, 0, 0, 0, 0, 0),    0, 0, 4'b1001, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(7, 0, 0, 0, 0, 0),    8'h12, 0, 4'b1001, 0, 1, 0, 9'h012, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h12, 0, 4'b1001, 4'b0001, 1, 0, 9'h1EC, 4'b1000));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h12, 0, 4'b1001, 4'b0001, 1, 0, 9'h012, 0));
        tbl.push_back(mk(mkw(1, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(1, 0, 0, 0, 0, 1),    0, 0, 0, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h34, 0, 4'b1000, 0, 0, 0, 9'h034, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h34, 0, 4'b1000, 0, 0, 0, 9'h1EC, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h34, 0, 4'b1000, 0, 0, 0, 9'h1EC, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h34, 0, 4'b1000, 0, 1, 0, 9'h1EC, 4'b1000));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h34, 0, 4'b1000, 0, 1, 0, 9'h034, 0));
        tbl.push_back(mk(mkw(5, 8'h40, 0, 0, 0, 1), 0, 0, 4'b1000, 0, 1, 0, 9'h140, 0));
        tbl.push_back(mk(mkw(5, 8'h41, 0, 0, 0, 0), 0, 0, 4'b1000, 0, 1, 1, 9'h1F0, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h56, 0, 4'b1000, 0, 1, 0, 9'h056, 0));
        tbl.push_back(mk(mkw(6, 0, 0, 0, 0, 0),    0, 0, 4'b1000, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(1, 0, 0, 0, 0, 0),    0, 0, 0, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(1, 0, 0, 0, 0, 0),    0, 0, 4'b1000, 0, 1, 0, 9'h100, 0));
        tbl.push_back(mk(mkw(0, 0, 0, 0, 0, 0),    8'h56, 0, 4'b1000, 0, 1, 0, 9'h1EC, 4'b1000));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].w, tbl[i].db, tbl[i].cnd, tbl[i].irqv, tbl[i].msk, tbl[i].rdyv, tbl[i].rstv);
            check($sformatf("vec%0d_addr", i), 32'(rom_addr), 32'(tbl[i].ea));
            check($sformatf("vec%0d_ack", i), 32'(irq_ack), 32'(tbl[i].eack));
        end

        // randomized cycles against the model
        irq_r = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) irq_r[b] = ~irq_r[b];
            end
            step($urandom, 8'($urandom), 8'($urandom), irq_r,
                 ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
                 ($urandom_range(0, 9) != 0), ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
